// File: rtl/avlmm_arb2.sv
// avlmm_arb2: two-master round-robin arbiter in front of one
// Avalon-MM register slave with fixed read latency of one cycle.
module avlmm_arb2 #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [WORD_WIDTH-1:0] m0_writedata,
  output logic                  m0_waitrequest,
  output logic [WORD_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [WORD_WIDTH-1:0] m1_writedata,
  output logic                  m1_waitrequest,
  output logic [WORD_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  s_read,
  output logic                  s_write,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [WORD_WIDTH-1:0] s_writedata,
  input  logic [WORD_WIDTH-1:0] s_readdata,
  input  logic                  s_waitrequest
);

  logic run;
  logic prio;
  logic rd_pend;
  logic rd_own;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic acc;

  // Requests are masked until the first clock after reset release.
  always_comb begin
    req0 = run & (m0_read | m0_write);
    req1 = run & (m1_read | m1_write);
    gnt0 = req0 & (~req1 | ~prio);
    gnt1 = req1 & (~req0 | prio);
  end

  // Forward the granted command; read+write collapses to a write.
  always_comb begin
    s_read      = 1'b0;
    s_write     = 1'b0;
    s_address   = m0_address;
    s_writedata = m0_writedata;
    unique case (1'b1)
      gnt0: begin
        s_read  = m0_read & ~m0_write;
        s_write = m0_write;
      end
      gnt1: begin
        s_read      = m1_read & ~m1_write;
        s_write     = m1_write;
        s_address   = m1_address;
        s_writedata = m1_writedata;
      end
      default: ;
    endcase
  end

  // Stall everyone but the granted master; tag returning read data.
  always_comb begin
    acc              = (s_read | s_write) & ~s_waitrequest;
    m0_waitrequest   = gnt0 ? s_waitrequest : 1'b1;
    m1_waitrequest   = gnt1 ? s_waitrequest : 1'b1;
    m0_readdata      = s_readdata;
    m1_readdata      = s_readdata;
    m0_readdatavalid = run & rd_pend & ~rd_own;
    m1_readdatavalid = run & rd_pend & rd_own;
  end

  // Run flag gates all handshakes while reset is or was just active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Hand preference to the other master after every accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   prio <= 1'b0;
    else if (acc) prio <= gnt0;
  end

  // Remember who owns the read data arriving next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_own  <= 1'b0;
    end else begin
      rd_pend <= acc & s_read;
      if (acc & s_read) rd_own <= gnt1;
    end
  end

endmodule

// File: tb/tb_avlmm_arb2.sv
// tb_avlmm_arb2: directed and random traffic from two masters,
// scoreboarded against a transaction-level model of the arbiter.
module tb_avlmm_arb2;

  typedef struct {
    bit          sr;
    bit          sw;
    logic [3:0]  a;
    logic [31:0] wd;
    bit          wr0;
    bit          wr1;
    bit          v0;
    bit          v1;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_rd [2];
  logic        m_wr [2];
  logic [3:0]  m_ad [2];
  logic [31:0] m_wd [2];
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        s_read, s_write;
  logic [3:0]  s_address;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata = '0;
  logic        s_wait = 1'b0;

  logic [31:0] mem   [16];
  logic [31:0] mem_m [16];
  exp_t        expq [$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          run_m = 0;
  int          prio_m = 0;
  int          pend_m = 0;
  int          own_m = 0;
  logic [31:0] pend_data = '0;
  bit          acc0, acc1;

  avlmm_arb2 #(.WORD_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_read(m_rd[0]), .m0_write(m_wr[0]),
    .m0_address(m_ad[0]), .m0_writedata(m_wd[0]),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m_rd[1]), .m1_write(m_wr[1]),
    .m1_address(m_ad[1]), .m1_writedata(m_wd[1]),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_wait)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 32'hA5A5_0000 | i;
      mem_m[i] = 32'hA5A5_0000 | i;
    end
  end

  // Register slave: data one cycle after an accepted read.
  always @(posedge clk) begin
    if (s_read && !s_wait) s_readdata <= mem[s_address];
    else                   s_readdata <= $urandom;
    if (s_write && !s_wait) mem[s_address] <= s_writedata;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exv);
    n_assert++;
    if (act !== exv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exv, $time);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("s_read", 32'(s_read), 32'(e.sr));
      chk("s_write", 32'(s_write), 32'(e.sw));
      if (e.sr || e.sw) chk("s_address", 32'(s_address), 32'(e.a));
      if (e.sw) chk("s_writedata", s_writedata, e.wd);
      chk("m0_waitrequest", 32'(m0_waitrequest), 32'(e.wr0));
      chk("m1_waitrequest", 32'(m1_waitrequest), 32'(e.wr1));
      chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(e.v0));
      chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(e.v1));
      if (e.v0) chk("m0_readdata", m0_readdata, e.rd);
      if (e.v1) chk("m1_readdata", m1_readdata, e.rd);
    end
  end

  task automatic setm(int n, bit r, bit w, logic [3:0] a,
                      logic [31:0] d);
    m_rd[n] = r;
    m_wr[n] = w;
    m_ad[n] = a;
    m_wd[n] = d;
  endtask

  task automatic reset_on();
    rst_n  = 1'b0;
    run_m  = 0;
    prio_m = 0;
    pend_m = 0;
    own_m  = 0;
  endtask

  // One bus cycle: predict, push, clock, advance the model.
  task automatic step(output bit a0, output bit a1);
    exp_t e;
    int   win;
    bit   rq0, rq1, rd, wr, acc;
    rq0 = (run_m != 0) && (m_rd[0] || m_wr[0]);
    rq1 = (run_m != 0) && (m_rd[1] || m_wr[1]);
    win = -1;
    if (rq0 && rq1) win = prio_m;
    else if (rq0)   win = 0;
    else if (rq1)   win = 1;
    rd = 0;
    wr = 0;
    e.a  = '0;
    e.wd = '0;
    if (win >= 0) begin
      wr   = m_wr[win];
      rd   = m_rd[win] && !m_wr[win];
      e.a  = m_ad[win];
      e.wd = m_wd[win];
    end
    e.sr  = rd;
    e.sw  = wr;
    e.wr0 = (win == 0) ? s_wait : 1'b1;
    e.wr1 = (win == 1) ? s_wait : 1'b1;
    e.v0  = (pend_m != 0) && (own_m == 0);
    e.v1  = (pend_m != 0) && (own_m == 1);
    e.rd  = pend_data;
    expq.push_back(e);
    @(posedge clk);
    a0 = 0;
    a1 = 0;
    if (rst_n) begin
      acc    = (win >= 0) && !s_wait && (rd || wr);
      pend_m = (acc && rd) ? 1 : 0;
      if (acc && rd) begin
        own_m     = win;
        pend_data = mem_m[e.a];
      end
      if (acc && wr) mem_m[e.a] = e.wd;
      if (acc) prio_m = (win == 0) ? 1 : 0;
      a0    = acc && (win == 0);
      a1    = acc && (win == 1);
      run_m = 1;
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    setm(0, 1, 0, 4'd0, 32'h0);
    setm(1, 0, 1, 4'd4, 32'h55);
    reset_on();
    @(posedge clk);
    #1;
    // reset: everything gated
    step(acc0, acc1);
    step(acc0, acc1);
    rst_n = 1'b1;
    step(acc0, acc1);
    for (int i = 0; i < 4; i++) begin
      step(acc0, acc1);
      if (acc0) setm(0, 0, 0, 4'd0, 32'h0);
      if (acc1) setm(1, 0, 0, 4'd0, 32'h0);
    end
    // contention: both hold reads for four cycles
    setm(0, 1, 0, 4'd1, 32'h0);
    setm(1, 1, 0, 4'd2, 32'h0);
    repeat (4) step(acc0, acc1);
    setm(0, 0, 0, 4'd0, 32'h0);
    setm(1, 0, 0, 4'd0, 32'h0);
    step(acc0, acc1);
    // single read of address 3 by m0
    setm(0, 1, 0, 4'd3, 32'h0);
    step(acc0, acc1);
    setm(0, 0, 0, 4'd0, 32'h0);
    step(acc0, acc1);
    // slave stall while m1 holds a write and m0 waits
    setm(1, 0, 1, 4'd5, 32'h1234);
    setm(0, 1, 0, 4'd6, 32'h0);
    s_wait = 1'b1;
    repeat (3) step(acc0, acc1);
    s_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(acc0, acc1);
      if (acc0) setm(0, 0, 0, 4'd0, 32'h0);
      if (acc1) setm(1, 0, 0, 4'd0, 32'h0);
    end
    // read+write together: write only, no return
    setm(0, 1, 1, 4'd7, 32'hDEAD_0007);
    step(acc0, acc1);
    setm(0, 0, 0, 4'd0, 32'h0);
    step(acc0, acc1);
    setm(0, 1, 0, 4'd7, 32'h0);
    step(acc0, acc1);
    setm(0, 0, 0, 4'd0, 32'h0);
    step(acc0, acc1);
    // reset while an m1 read is in flight
    setm(1, 1, 0, 4'd2, 32'h0);
    step(acc0, acc1);
    setm(1, 0, 0, 4'd0, 32'h0);
    reset_on();
    step(acc0, acc1);
    step(acc0, acc1);
    rst_n = 1'b1;
    step(acc0, acc1);
    setm(0, 1, 0, 4'd8, 32'h0);
    setm(1, 1, 0, 4'd9, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(acc0, acc1);
      if (acc0) setm(0, 0, 0, 4'd0, 32'h0);
      if (acc1) setm(1, 0, 0, 4'd0, 32'h0);
    end
    // random traffic; masters hold commands until accepted
    for (int i = 0; i < 2000; i++) begin
      s_wait = ($urandom_range(0, 3) == 0);
      step(acc0, acc1);
      for (int n = 0; n < 2; n++) begin
        int op;
        if ((n == 0 && acc0) || (n == 1 && acc1))
          setm(n, 0, 0, 4'd0, 32'h0);
        if (!m_rd[n] && !m_wr[n] && $urandom_range(0, 9) < 6) begin
          op = $urandom_range(0, 9);
          setm(n, op < 5 || op == 9, op >= 5,
               4'($urandom_range(0, 15)), $urandom);
        end
      end
    end
    setm(0, 0, 0, 4'd0, 32'h0);
    setm(1, 0, 0, 4'd0, 32'h0);
    s_wait = 1'b0;
    step(acc0, acc1);
    step(acc0, acc1);
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: got %0d expected 0 pending", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
